// File: rtl/priority_event_arbiter.sv
// -----------------------------------------------------------------------------
// priority_event_arbiter
//
// Sequential front end for the 8-to-3 priority encoding path. Single-cycle
// event pulses are captured into a sticky pending register. The highest-
// numbered pending line that is enabled by the mask is claimed and its index
// is presented downstream on a valid/ready handshake. An event that arrives on
// a line that is already pending, and is not being claimed that cycle, sets a
// sticky per-line overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   event_in   [7:0] event pulses, one bit per line
//   mask_wr    load mask_in into the enable mask
//   mask_in    [7:0] new enable mask (1 = line eligible)
//   out_ready  downstream accepts out_idx this cycle
//   ovf_clr    clear all overflow flags
//   out_valid  out_idx holds a claimed, unconsumed event
//   out_idx    [2:0] index of the claimed line
//   pending    [7:0] pending register
//   ovf        [7:0] sticky lost-event flags
// -----------------------------------------------------------------------------
module priority_event_arbiter #(
    parameter logic [7:0] MASK_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] event_in,
    input  logic       mask_wr,
    input  logic [7:0] mask_in,
    input  logic       out_ready,
    input  logic       ovf_clr,
    output logic       out_valid,
    output logic [2:0] out_idx,
    output logic [7:0] pending,
    output logic [7:0] ovf
);

    logic [7:0] pending_q, pending_d;
    logic [7:0] ovf_q,     ovf_d;
    logic [7:0] mask_q,    mask_d;
    logic       valid_q,   valid_d;
    logic [2:0] idx_q,     idx_d;

    logic [7:0] elig;
    logic [2:0] enc_idx;
    logic       load;
    logic [7:0] claim_onehot;

    // Selection looks only at registered state, so nothing on event_in or
    // out_ready can reach out_valid/out_idx combinationally.
    assign elig = pending_q & mask_q;

    // Highest set bit wins: ascending scan, later matches overwrite earlier.
    // NOTE: every always_comb output gets a default first so no latch is
    // inferred when no bit of elig is set.
    always_comb begin
        enc_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (elig[i]) begin
                enc_idx = 3'(i);
            end
        end
    end

    // A new index may be claimed when the output slot is empty or is being
    // emptied this very cycle.
    assign load         = (!valid_q || out_ready) && (elig != 8'd0);
    assign claim_onehot = load ? (8'd1 << enc_idx) : 8'd0;

    always_comb begin
        // Set wins over claim: an event on the line being claimed re-arms it.
        pending_d = (pending_q & ~claim_onehot) | event_in;

        // New overflow is ORed after the clear so it survives a same-cycle clear.
        ovf_d = (ovf_clr ? 8'd0 : ovf_q) | (event_in & pending_q & ~claim_onehot);

        mask_d = mask_wr ? mask_in : mask_q;

        valid_d = valid_q;
        idx_d   = idx_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = enc_idx;
        end else if (valid_q && out_ready) begin
            // out_idx keeps its last value after the drain.
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 8'd0;
            ovf_q     <= 8'd0;
            mask_q    <= MASK_RST;
            valid_q   <= 1'b0;
            idx_q     <= 3'd0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_priority_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_priority_event_arbiter
//
// Directed stimulus for priority_event_arbiter. Expected issued indices are
// pushed into a queue as stimulus is applied; a monitor pops and compares on
// every accepted handshake. Register outputs are checked directly at chosen
// points of each scenario.
// -----------------------------------------------------------------------------
module tb_priority_event_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] event_in;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       out_ready;
    logic       ovf_clr;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic [7:0] ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [2:0] exp_q[$];

    priority_event_arbiter #(.MASK_RST(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .event_in  (event_in),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next
    // rising edge, since inputs are stable between #1 after posedge and then.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_issue: got idx %0d, expected none (t=%0t)", out_idx, $time);
            end else begin
                check("issue_idx", 32'(out_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        event_in  = 8'd0;
        mask_wr   = 1'b0;
        mask_in   = 8'd0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_pending", 32'(pending),   32'd0);
        check("rst_ovf",     32'(ovf),       32'd0);
        check("rst_idx",     32'(out_idx),   32'd0);

        // ---------------- Priority order 5,2,1 ----------------
        out_ready = 1'b1;
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd1);
        event_in = 8'b0010_0110;
        tick();                               // edge N: captured into pending
        event_in = 8'd0;
        check("prio_pending_n1", 32'(pending),   32'h26);
        check("prio_valid_n1",   32'(out_valid), 32'd0);
        tick();                               // N+1: first claim
        check("prio_valid_n2",   32'(out_valid), 32'd1);
        check("prio_idx_n2",     32'(out_idx),   32'd5);
        tick();
        check("prio_idx_n3",     32'(out_idx),   32'd2);
        tick();
        check("prio_idx_n4",     32'(out_idx),   32'd1);
        tick();
        check("prio_valid_end",  32'(out_valid), 32'd0);
        check("prio_pending_end",32'(pending),   32'd0);

        // ---------------- Backpressure ----------------
        out_ready = 1'b0;
        event_in  = 8'b0000_1000;
        tick();
        event_in  = 8'd0;
        tick();                               // line 3 claimed
        for (int i = 0; i < 4; i++) begin
            event_in = (i == 0) ? 8'b0100_0000 : 8'd0;
            tick();
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_idx_hold",   32'(out_idx),   32'd3);
        end
        event_in = 8'd0;
        check("bp_pending6", 32'(pending), 32'h40);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd6);
        out_ready = 1'b1;
        tick();                               // 3 accepted, 6 loaded
        check("bp_idx_next", 32'(out_idx),   32'd6);
        check("bp_valid_next", 32'(out_valid), 32'd1);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // ---------------- Overflow on line 2 ----------------
        out_ready = 1'b0;
        event_in  = 8'b1000_0000;
        tick();
        event_in  = 8'b0000_0100;
        tick();                               // 7 claimed, line 2 becomes pending
        check("ovf_none_yet", 32'(ovf), 32'd0);
        tick();                               // second line-2 event: lost
        tick();                               // third line-2 event: lost
        event_in  = 8'd0;
        check("ovf_line2", 32'(ovf),     32'h04);
        check("ovf_idx7",  32'(out_idx), 32'd7);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd2);
        out_ready = 1'b1;
        tick();
        check("ovf_idx2", 32'(out_idx), 32'd2);
        tick();
        check("ovf_drained_pending", 32'(pending), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // ---------------- Set wins on claim cycle ----------------
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd4);
        event_in = 8'b0001_0000;
        tick();
        tick();                               // claim of 4 with a new 4 event
        event_in = 8'd0;
        check("setwin_pending", 32'(pending),   32'h10);
        check("setwin_ovf",     32'(ovf),       32'd0);
        check("setwin_idx",     32'(out_idx),   32'd4);
        tick();                               // 4 accepted, 4 claimed again
        check("setwin_valid2",  32'(out_valid), 32'd1);
        check("setwin_pending2",32'(pending),   32'd0);
        tick();
        check("setwin_drained", 32'(out_valid), 32'd0);
        check("setwin_ovf_end", 32'(ovf),       32'd0);

        // ---------------- Mask ----------------
        exp_q.push_back(3'd0);
        mask_wr  = 1'b1;
        mask_in  = 8'b0111_1111;
        tick();
        mask_wr  = 1'b0;
        event_in = 8'b1000_0001;
        tick();
        event_in = 8'd0;
        tick();                               // line 0 claimed, 7 held back
        check("mask_idx0",     32'(out_idx), 32'd0);
        check("mask_pending7", 32'(pending), 32'h80);
        tick();
        check("mask_idle",     32'(out_valid), 32'd0);
        check("mask_pending7b",32'(pending),   32'h80);
        exp_q.push_back(3'd7);
        mask_wr  = 1'b1;
        mask_in  = 8'hFF;
        tick();                               // mask updated, not yet selected
        mask_wr  = 1'b0;
        check("unmask_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("unmask_idx7", 32'(out_idx),   32'd7);
        check("unmask_valid",32'(out_valid), 32'd1);
        tick();
        check("unmask_drained", 32'(out_valid), 32'd0);

        // ---------------- ovf_clr collision ----------------
        out_ready = 1'b0;
        event_in  = 8'b1000_0000;
        tick();
        event_in  = 8'b0000_0010;
        tick();                               // 7 claimed, line 1 pending
        tick();                               // line-1 overflow
        check("clr_pre", 32'(ovf), 32'h02);
        ovf_clr = 1'b1;
        tick();                               // clear + new overflow together
        event_in = 8'd0;
        check("clr_collision", 32'(ovf), 32'h02);
        tick();                               // clear alone
        ovf_clr = 1'b0;
        check("clr_alone", 32'(ovf), 32'd0);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd1);
        out_ready = 1'b1;
        tick();
        tick();
        check("clr_drained", 32'(out_valid), 32'd0);

        // ---------------- Reset mid-handshake ----------------
        out_ready = 1'b0;
        event_in  = 8'b0010_0000;
        tick();
        event_in  = 8'b0000_0001;
        tick();                               // 5 claimed, line 0 pending
        tick();                               // line-0 overflow
        event_in  = 8'd0;
        mask_wr   = 1'b1;
        mask_in   = 8'h00;                    // reset must restore the mask
        tick();
        mask_wr   = 1'b0;
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_idx",   32'(out_idx),   32'd5);
        check("mid_ovf",   32'(ovf),       32'h01);
        #2 rst = 1'b1;
        #1;                                   // well before the next edge
        check("arst_valid",   32'(out_valid), 32'd0);
        check("arst_pending", 32'(pending),   32'd0);
        check("arst_ovf",     32'(ovf),       32'd0);
        check("arst_idx",     32'(out_idx),   32'd0);
        tick();
        rst = 1'b0;
        exp_q.push_back(3'd7);
        out_ready = 1'b1;
        event_in  = 8'b1000_0000;
        tick();
        event_in  = 8'd0;
        tick();
        check("arst_mask_ff", 32'(out_valid), 32'd1);
        check("arst_mask_idx",32'(out_idx),   32'd7);
        tick();
        tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
